noc_serial_receiver_fifo: RTL and testbench

- Parametrised successor to the single-packet NoC serial receiver.
- Deserialises flits arriving on a node_port.down interface into packets of up to N_FLITS payload flits.
- Supports short packets terminated early by TAIL.
- Queues up to DEPTH complete packets in an internal FIFO, drained through a valid/ready consumer port, so the NoC is not stalled while the consumer processes a packet.

---
 rtl/noc_serial_receiver_fifo_if.sv | 15 +
 rtl/noc_serial_receiver_fifo.sv | 149 ++++++++++++++
 tb/tb_noc_serial_receiver_fifo.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_serial_receiver_fifo_if.sv
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 8
`endif
// NoC flit link: flit = {kind[1:0], data}; the sender drives flit/enable, the receiver answers with ack/rej.
interface node_port;
  logic [`FLIT_DATA_WIDTH+1:0] flit;
  logic                        enable;
  logic                        ack;
  logic                        rej;

  modport master (output flit, enable, input ack, rej);
  modport slave  (input flit, enable, output ack, rej);
  modport up     (output flit, enable, input ack, rej);
  modport down   (input flit, enable, output ack, rej);
endinterface

// File: rtl/noc_serial_receiver_fifo.sv
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 8
`endif
// Reassembles HEADER/DATA/TAIL flits into packets and queues up to DEPTH of them; commit shows on out_valid one cycle later.
// A HEADER is rejected while the queue is full; a flit is consumed only when enable && ack.
module noc_serial_receiver_fifo #(
  parameter int PACKET_BITS  = 16,
  parameter int PADDING_BITS = 0,
  parameter int DEPTH        = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  node_port.down                                down,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [PACKET_BITS-1:0]                out_packet,
  output logic [(PADDING_BITS>0 ? PADDING_BITS : 1)-1:0] out_padding,
  output logic [$clog2((PACKET_BITS+`FLIT_DATA_WIDTH-1)/`FLIT_DATA_WIDTH+1)-1:0] out_nflits,
  output logic [$clog2(DEPTH+1)-1:0]            occupancy,
  output logic                                  err_stray
);
  localparam int FW      = `FLIT_DATA_WIDTH;
  localparam int N_FLITS = (PACKET_BITS + FW - 1) / FW;
  localparam int CW      = $clog2(N_FLITS + 1);
  localparam int PW      = (PADDING_BITS > 0) ? PADDING_BITS : 1;
  localparam int OW      = $clog2(DEPTH + 1);
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW      = N_FLITS * FW;

  localparam logic [1:0] K_HEADER = 2'd1;
  localparam logic [1:0] K_DATA   = 2'd2;
  localparam logic [1:0] K_TAIL   = 2'd3;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;

  logic [0:0]             state;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          asm_buf;
  logic [BW-1:0]          next_buf;
  logic [PW-1:0]          pad_q;
  logic [PW-1:0]          hdr_free;
  logic [FW+PW-1:0]       free_ext;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [OW-1:0]          occ;

  logic [PACKET_BITS-1:0] mem_pkt [DEPTH];
  logic [PW-1:0]          mem_pad [DEPTH];
  logic [CW-1:0]          mem_nf  [DEPTH];

  logic [1:0]             kind;
  logic [FW-1:0]          data;
  logic                   is_hdr, is_dat, is_tail;
  logic                   full, take, hdr_accept, stored, commit, pop;
  logic                   unused_sink;

  assign kind    = down.flit[FW+1:FW];
  assign data    = down.flit[FW-1:0];
  assign is_hdr  = (kind == K_HEADER);
  assign is_tail = (kind == K_TAIL);
  assign is_dat  = (kind == K_DATA) || is_tail;
  assign full    = (occ == OW'(DEPTH));

  // Flush and reset cycles neither accept nor reject, so the sender simply retries.
  always_comb begin
    down.ack = 1'b0;
    down.rej = 1'b0;
    if (!rst && !flush) begin
      if (state == S_IDLE && is_hdr && full) down.rej = 1'b1;
      else                                   down.ack = 1'b1;
    end
  end

  assign take       = down.enable && down.ack;
  assign hdr_accept = take && (state == S_IDLE) && is_hdr;
  assign stored     = take && (state == S_RECV) && is_dat;
  assign commit     = stored && (is_tail || cnt == CW'(N_FLITS - 1));
  assign err_stray  = take && (state == S_IDLE) && is_dat;
  assign pop        = out_valid && out_ready;

  assign free_ext = {{PW{1'b0}}, data};
  assign hdr_free = (PADDING_BITS > 0) ? free_ext[PW-1:0] : '0;

  always_comb begin
    next_buf = asm_buf;
    for (int i = 0; i < N_FLITS; i++)
      if (cnt == CW'(i)) next_buf[i*FW +: FW] = data;
  end

  assign unused_sink = ^{free_ext, next_buf};

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      asm_buf <= '0;
      pad_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pkt[i] <= '0;
        mem_pad[i] <= '0;
        mem_nf[i]  <= '0;
      end
    end else if (flush) begin
      state  <= S_IDLE;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (hdr_accept) begin
        state   <= S_RECV;
        cnt     <= '0;
        asm_buf <= '0;
        pad_q   <= hdr_free;
      end
      if (stored) begin
        asm_buf <= next_buf;
        cnt     <= cnt + 1'b1;
      end
      // A header is only taken with a free slot, so a commit always has room.
      if (commit) begin
        state           <= S_IDLE;
        mem_pkt[wr_ptr] <= next_buf[PACKET_BITS-1:0];
        mem_pad[wr_ptr] <= pad_q;
        mem_nf[wr_ptr]  <= cnt + 1'b1;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (commit && !pop)      occ <= occ + 1'b1;
      else if (!commit && pop) occ <= occ - 1'b1;
    end
  end

  assign out_valid   = (occ != '0);
  assign out_packet  = mem_pkt[rd_ptr];
  assign out_padding = mem_pad[rd_ptr];
  assign out_nflits  = mem_nf[rd_ptr];
  assign occupancy   = occ;

endmodule

// File: tb/tb_noc_serial_receiver_fifo.sv
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 8
`endif
// Directed flit sequences; expected packets are queued at send time and checked by a separate pop monitor.
module tb_noc_serial_receiver_fifo;
  localparam logic [1:0] K_HDR  = 2'd1;
  localparam logic [1:0] K_DAT  = 2'd2;
  localparam logic [1:0] K_TAIL = 2'd3;

  logic        clk = 1'b0;
  logic        rst, flush, out_valid, out_ready, err_stray;
  logic [15:0] out_packet;
  logic [3:0]  out_padding;
  logic [1:0]  out_nflits;
  logic [1:0]  occupancy;

  node_port dport();

  noc_serial_receiver_fifo #(.PACKET_BITS(16), .PADDING_BITS(4), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .down       (dport),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_packet (out_packet),
    .out_padding(out_padding),
    .out_nflits (out_nflits),
    .occupancy  (occupancy),
    .err_stray  (err_stray)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pkt;
    logic [3:0]  pad;
    logic [1:0]  nf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic void expect_pkt(input logic [15:0] p, input logic [3:0] pad, input logic [1:0] nf);
    exp_t e;
    e.pkt = p;
    e.pad = pad;
    e.nf  = nf;
    exp_q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] k, input logic [7:0] d, input logic exp_ack, input string nm);
    dport.flit   = {k, d};
    dport.enable = 1'b1;
    @(negedge clk);
    check({nm, "_ack"}, 32'(dport.ack), 32'(exp_ack));
    check({nm, "_rej"}, 32'(dport.rej), 32'(!exp_ack));
    step();
    dport.enable = 1'b0;
    dport.flit   = '0;
  endtask

  task automatic pop_one();
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Monitor: every handshake on the output port consumes one expected packet.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got packet %h, required no packet", out_packet);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_packet",  32'(out_packet),  32'(e.pkt));
        check("out_padding", 32'(out_padding), 32'(e.pad));
        check("out_nflits",  32'(out_nflits),  32'(e.nf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    out_ready    = 1'b0;
    dport.flit   = '0;
    dport.enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid",  32'(out_valid),   32'd0);
    check("rst_occ",    32'(occupancy),   32'd0);
    check("rst_err",    32'(err_stray),   32'd0);
    check("rst_packet", 32'(out_packet),  32'd0);
    check("rst_pad",    32'(out_padding), 32'd0);
    check("rst_nflits", 32'(out_nflits),  32'd0);

    // Full two-flit packet, latency of out_valid
    send(K_HDR, 8'h05, 1'b1, "t1_hdr");
    send(K_DAT, 8'h34, 1'b1, "t1_d0");
    @(negedge clk);
    check("t1_valid_early", 32'(out_valid), 32'd0);
    expect_pkt(16'h1234, 4'h5, 2'd2);
    send(K_TAIL, 8'h12, 1'b1, "t1_tail");
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_occ",   32'(occupancy), 32'd1);
    pop_one();
    @(negedge clk);
    check("t1_occ_after_pop", 32'(occupancy), 32'd0);

    // Short packet
    expect_pkt(16'h00AB, 4'hA, 2'd1);
    send(K_HDR,  8'h0A, 1'b1, "t2_hdr");
    send(K_TAIL, 8'hAB, 1'b1, "t2_tail");
    pop_one();

    // Back-pressure: full queue rejects headers, even with a same-cycle pop
    step();
    expect_pkt(16'h2211, 4'h1, 2'd2);
    send(K_HDR,  8'h01, 1'b1, "t3_p1_hdr");
    send(K_DAT,  8'h11, 1'b1, "t3_p1_d0");
    send(K_TAIL, 8'h22, 1'b1, "t3_p1_tail");
    expect_pkt(16'h0033, 4'h2, 2'd1);
    send(K_HDR,  8'h02, 1'b1, "t3_p2_hdr");
    send(K_TAIL, 8'h33, 1'b1, "t3_p2_tail");
    @(negedge clk);
    check("t3_occ_full", 32'(occupancy), 32'd2);
    send(K_HDR, 8'h03, 1'b0, "t3_full_rej");
    step();
    out_ready = 1'b1;
    send(K_HDR, 8'h03, 1'b0, "t3_rej_with_pop");
    out_ready = 1'b0;
    @(negedge clk);
    check("t3_occ_after_pop", 32'(occupancy), 32'd1);
    expect_pkt(16'h5544, 4'h3, 2'd2);
    send(K_HDR, 8'h03, 1'b1, "t3_retry_hdr");
    send(K_DAT, 8'h44, 1'b1, "t3_p3_d0");
    send(K_DAT, 8'h55, 1'b1, "t3_p3_d1");
    @(negedge clk);
    check("t3_occ_refull", 32'(occupancy), 32'd2);
    pop_one();
    pop_one();
    @(negedge clk);
    check("t3_occ_drained", 32'(occupancy), 32'd0);

    // Repeated header ignored, commit at N_FLITS without TAIL
    expect_pkt(16'h0201, 4'h6, 2'd2);
    send(K_HDR, 8'h06, 1'b1, "t4_hdr");
    send(K_HDR, 8'h07, 1'b1, "t4_hdr_rep");
    send(K_DAT, 8'h01, 1'b1, "t4_d0");
    send(K_DAT, 8'h02, 1'b1, "t4_d1");
    @(negedge clk);
    check("t4_occ", 32'(occupancy), 32'd1);
    pop_one();

    // Stray DATA in IDLE
    dport.flit   = {K_DAT, 8'h55};
    dport.enable = 1'b1;
    @(negedge clk);
    check("t5_ack", 32'(dport.ack), 32'd1);
    check("t5_err", 32'(err_stray), 32'd1);
    step();
    dport.enable = 1'b0;
    dport.flit   = '0;
    @(negedge clk);
    check("t5_err_clear", 32'(err_stray), 32'd0);
    check("t5_occ",       32'(occupancy), 32'd0);

    // Mid-packet flush
    send(K_HDR, 8'h01, 1'b1, "t6a_hdr");
    send(K_DAT, 8'h99, 1'b1, "t6a_d0");
    flush        = 1'b1;
    dport.flit   = {K_DAT, 8'hEE};
    dport.enable = 1'b1;
    @(negedge clk);
    check("t6a_flush_ack", 32'(dport.ack), 32'd0);
    check("t6a_flush_rej", 32'(dport.rej), 32'd0);
    step();
    flush        = 1'b0;
    dport.enable = 1'b0;
    dport.flit   = '0;
    @(negedge clk);
    check("t6a_occ",   32'(occupancy), 32'd0);
    check("t6a_valid", 32'(out_valid), 32'd0);
    expect_pkt(16'h3412, 4'h8, 2'd2);
    send(K_HDR,  8'h08, 1'b1, "t6a_hdr2");
    send(K_DAT,  8'h12, 1'b1, "t6a_d2");
    send(K_TAIL, 8'h34, 1'b1, "t6a_tail2");
    pop_one();

    // Mid-packet reset
    send(K_HDR, 8'h0A, 1'b1, "t6b_hdr");
    send(K_DAT, 8'h77, 1'b1, "t6b_d0");
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6b_occ",    32'(occupancy),  32'd0);
    check("t6b_packet", 32'(out_packet), 32'd0);
    check("t6b_pad",    32'(out_padding), 32'd0);
    check("t6b_nflits", 32'(out_nflits), 32'd0);
    expect_pkt(16'h5AC3, 4'hB, 2'd2);
    send(K_HDR,  8'h0B, 1'b1, "t6b_hdr2");
    send(K_DAT,  8'hC3, 1'b1, "t6b_d2");
    send(K_TAIL, 8'h5A, 1'b1, "t6b_tail2");
    pop_one();

    // Flush with a full queue; those packets must never appear
    send(K_HDR,  8'h01, 1'b1, "t6c_p1_hdr");
    send(K_TAIL, 8'h66, 1'b1, "t6c_p1_tail");
    send(K_HDR,  8'h02, 1'b1, "t6c_p2_hdr");
    send(K_TAIL, 8'h77, 1'b1, "t6c_p2_tail");
    @(negedge clk);
    check("t6c_occ_full", 32'(occupancy), 32'd2);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("t6c_occ",   32'(occupancy), 32'd0);
    check("t6c_valid", 32'(out_valid), 32'd0);
    expect_pkt(16'h0F0E, 4'hC, 2'd2);
    send(K_HDR,  8'h0C, 1'b1, "t6c_hdr2");
    send(K_DAT,  8'h0E, 1'b1, "t6c_d2");
    send(K_TAIL, 8'h0F, 1'b1, "t6c_tail2");
    @(negedge clk);
    check("t6c_occ_after", 32'(occupancy), 32'd1);

    // Drain anything still expected, bounded
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    out_ready = 1'b0;
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
